// File: rtl/fb_sched_pkg.sv
// Shared encodings and defaults for the triple-buffer frame scheduler.
package fb_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    RUN        = 2'd2
  } fb_state_e;

  localparam logic [1:0] RST_WR_IDX  = 2'd0;
  localparam logic [1:0] RST_RDY_IDX = 2'd1;
  localparam logic [1:0] RST_RD_IDX  = 2'd2;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h1000_0000;
  localparam logic [31:0] DEF_FRAME_BYTES = 32'h0009_6000;

endpackage

// File: rtl/fb_sat_counter.sv
// Saturating status counter; clear wins over a same-cycle increment.
module fb_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer scheduler: rotates writer/ready/reader buffer indices so the
// reader only ever switches onto a fully written frame.
module frame_buffer_scheduler
  import fb_sched_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEF_BASE_ADDR),
  parameter logic [ADDR_W-1:0] FRAME_BYTES = ADDR_W'(DEF_FRAME_BYTES),
  parameter int                CNT_W       = 16
) (
  input  logic              clk_100Mhz,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic              clr_cnt,
  input  logic              wr_frame_start,
  input  logic              wr_frame_done,
  input  logic              rd_frame_start,
  output logic [ADDR_W-1:0] wr_base_addr,
  output logic [ADDR_W-1:0] rd_base_addr,
  output logic [1:0]        wr_idx,
  output logic [1:0]        rd_idx,
  output logic              rd_valid,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  dropped_cnt,
  output logic [CNT_W-1:0]  repeat_cnt,
  output logic [CNT_W-1:0]  abort_cnt
);

  // Shift-add only: idx is at most 2, so two conditional adds cover it.
  function automatic logic [ADDR_W-1:0] idx_addr(input logic [1:0] idx);
    logic [ADDR_W-1:0] a;
    a = BASE_ADDR;
    if (idx[0]) a = a + FRAME_BYTES;
    if (idx[1]) a = a + (FRAME_BYTES << 1);
    return a;
  endfunction

  fb_state_e  st_q, st_d;
  logic [1:0] wr_idx_q, rdy_idx_q, rd_idx_q;
  logic [1:0] wr_idx_d, rdy_idx_d, rd_idx_d;
  logic       fresh_q, fresh_d, writing_q, writing_d, rd_valid_q, rd_valid_d;
  logic       trk_en, rd_en, done_q, rd_q;
  logic       drop_inc, rep_inc, abort_inc;

  // FSM: state register
  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) st_q <= IDLE;
    else            st_q <= st_d;
  end

  // FSM: next state
  always_comb begin
    st_d = st_q;
    if (!enable) st_d = IDLE;
    else begin
      case (st_q)
        IDLE:       st_d = WAIT_FIRST;
        WAIT_FIRST: if (done_q) st_d = RUN;
        RUN:        st_d = RUN;
        default:    st_d = IDLE;
      endcase
    end
  end

  // FSM: outputs (event qualification)
  always_comb begin
    trk_en = enable && (st_q != IDLE);
    rd_en  = enable && (st_q == RUN);
    done_q = trk_en && wr_frame_done && writing_q;
    rd_q   = rd_en && rd_frame_start;
  end

  // Index rotation: a completing write is applied before a same-cycle read,
  // so the reader picks up the frame that just finished.
  always_comb begin
    wr_idx_d   = wr_idx_q;
    rdy_idx_d  = rdy_idx_q;
    rd_idx_d   = rd_idx_q;
    fresh_d    = fresh_q;
    writing_d  = writing_q;
    rd_valid_d = rd_valid_q;
    drop_inc   = 1'b0;
    rep_inc    = 1'b0;
    abort_inc  = 1'b0;
    if (!enable) begin
      wr_idx_d   = RST_WR_IDX;
      rdy_idx_d  = RST_RDY_IDX;
      rd_idx_d   = RST_RD_IDX;
      fresh_d    = 1'b0;
      writing_d  = 1'b0;
      rd_valid_d = 1'b0;
    end else begin
      if (done_q) begin
        wr_idx_d   = rdy_idx_q;
        rdy_idx_d  = wr_idx_q;
        writing_d  = 1'b0;
        drop_inc   = fresh_q;
        fresh_d    = 1'b1;
        rd_valid_d = 1'b1;
      end
      if (rd_q) begin
        if (fresh_d) begin
          rd_idx_d  = rdy_idx_d;
          rdy_idx_d = rd_idx_q;
          fresh_d   = 1'b0;
        end else begin
          rep_inc = 1'b1;
        end
      end
      if (trk_en && wr_frame_start) begin
        abort_inc = writing_d;
        writing_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100Mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_idx_q     <= RST_WR_IDX;
      rdy_idx_q    <= RST_RDY_IDX;
      rd_idx_q     <= RST_RD_IDX;
      fresh_q      <= 1'b0;
      writing_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_base_addr <= idx_addr(RST_WR_IDX);
      rd_base_addr <= idx_addr(RST_RD_IDX);
    end else begin
      wr_idx_q     <= wr_idx_d;
      rdy_idx_q    <= rdy_idx_d;
      rd_idx_q     <= rd_idx_d;
      fresh_q      <= fresh_d;
      writing_q    <= writing_d;
      rd_valid_q   <= rd_valid_d;
      // Addresses trail the indices by one cycle to keep the adders off the index path.
      wr_base_addr <= idx_addr(wr_idx_q);
      rd_base_addr <= idx_addr(rd_idx_q);
    end
  end

  assign wr_idx   = wr_idx_q;
  assign rd_idx   = rd_idx_q;
  assign rd_valid = rd_valid_q;
  assign state    = st_q;

  fb_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk_100Mhz), .rst_n(sys_rst_n), .clr(clr_cnt), .inc(drop_inc),  .cnt(dropped_cnt)
  );
  fb_sat_counter #(.CNT_W(CNT_W)) u_rep_cnt (
    .clk(clk_100Mhz), .rst_n(sys_rst_n), .clr(clr_cnt), .inc(rep_inc),   .cnt(repeat_cnt)
  );
  fb_sat_counter #(.CNT_W(CNT_W)) u_abort_cnt (
    .clk(clk_100Mhz), .rst_n(sys_rst_n), .clr(clr_cnt), .inc(abort_inc), .cnt(abort_cnt)
  );

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Table-driven bench for frame_buffer_scheduler with a per-cycle expectation queue.
module tb_frame_buffer_scheduler;

  localparam int CW = 2;  // narrow counters so saturation is reachable

  logic          clk_100Mhz = 1'b0;
  logic          sys_rst_n  = 1'b1;
  logic          enable = 1'b0, clr_cnt = 1'b0;
  logic          wr_frame_start = 1'b0, wr_frame_done = 1'b0, rd_frame_start = 1'b0;
  logic [31:0]   wr_base_addr, rd_base_addr;
  logic [1:0]    wr_idx, rd_idx, state;
  logic          rd_valid;
  logic [CW-1:0] dropped_cnt, repeat_cnt, abort_cnt;

  frame_buffer_scheduler #(.CNT_W(CW)) dut (
    .clk_100Mhz(clk_100Mhz), .sys_rst_n(sys_rst_n), .enable(enable), .clr_cnt(clr_cnt),
    .wr_frame_start(wr_frame_start), .wr_frame_done(wr_frame_done),
    .rd_frame_start(rd_frame_start), .wr_base_addr(wr_base_addr),
    .rd_base_addr(rd_base_addr), .wr_idx(wr_idx), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .state(state), .dropped_cnt(dropped_cnt), .repeat_cnt(repeat_cnt), .abort_cnt(abort_cnt)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct {
    logic en, clr, ws, wd, rs;
    logic [1:0] wi, ri, st;
    logic v;
    logic [CW-1:0] dr, rp, ab;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  function automatic logic [31:0] baddr(input logic [1:0] idx);
    return 32'h1000_0000 + 32'(idx) * 32'h0009_6000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, clr, ws, wd, rs, input logic [1:0] wi, ri, st,
                     input logic v, input int dr, rp, ab);
    vec_t r;
    r.en = en; r.clr = clr; r.ws = ws; r.wd = wd; r.rs = rs;
    r.wi = wi; r.ri = ri; r.st = st; r.v = v;
    r.dr = CW'(dr); r.rp = CW'(rp); r.ab = CW'(ab);
    vecs.push_back(r);
  endtask

  // Index permutation sanity, sampled away from the active edge.
  always @(negedge clk_100Mhz) begin
    if (sys_rst_n) begin
      total++;
      if (wr_idx == rd_idx || wr_idx > 2'd2 || rd_idx > 2'd2) begin
        bad++;
        $display("FAIL perm: wr_idx=%0d rd_idx=%0d", wr_idx, rd_idx);
      end
    end
  end

  initial begin
    vec_t e;
    logic [1:0] pwi, pri;

    //  en clr ws wd rs   wi ri st v   dr rp ab
    add(1, 0, 1, 0, 0,   0, 2, 1, 0,  0, 0, 0);  // start ignored in IDLE
    add(1, 0, 0, 1, 0,   0, 2, 1, 0,  0, 0, 0);  // stray done
    add(1, 0, 0, 0, 1,   0, 2, 1, 0,  0, 0, 0);  // read ignored in WAIT_FIRST
    add(1, 0, 1, 0, 0,   0, 2, 1, 0,  0, 0, 0);
    add(1, 0, 0, 1, 0,   1, 2, 2, 1,  0, 0, 0);  // first frame complete
    add(1, 0, 0, 0, 0,   1, 2, 2, 1,  0, 0, 0);
    add(1, 0, 0, 0, 1,   1, 0, 2, 1,  0, 0, 0);  // reader takes frame 0
    add(1, 0, 0, 0, 0,   1, 0, 2, 1,  0, 0, 0);
    add(1, 0, 1, 0, 0,   1, 0, 2, 1,  0, 0, 0);
    add(1, 0, 0, 1, 1,   2, 1, 2, 1,  0, 0, 0);  // simultaneous done+read
    add(1, 0, 1, 0, 0,   2, 1, 2, 1,  0, 0, 0);
    add(1, 0, 0, 1, 0,   0, 1, 2, 1,  0, 0, 0);
    add(1, 0, 1, 0, 0,   0, 1, 2, 1,  0, 0, 0);
    add(1, 0, 0, 1, 0,   2, 1, 2, 1,  1, 0, 0);  // overwritten unread frame
    add(1, 0, 0, 0, 1,   2, 0, 2, 1,  1, 0, 0);
    add(1, 0, 0, 0, 1,   2, 0, 2, 1,  1, 1, 0);
    add(1, 0, 0, 0, 1,   2, 0, 2, 1,  1, 2, 0);
    add(1, 0, 1, 0, 0,   2, 0, 2, 1,  1, 2, 0);
    add(1, 0, 1, 0, 0,   2, 0, 2, 1,  1, 2, 1);  // abort
    add(1, 0, 0, 1, 0,   1, 0, 2, 1,  1, 2, 1);
    add(1, 0, 1, 0, 0,   1, 0, 2, 1,  1, 2, 1);
    add(1, 0, 1, 1, 0,   2, 0, 2, 1,  2, 2, 1);  // start+done: not an abort
    add(1, 0, 0, 1, 0,   1, 0, 2, 1,  3, 2, 1);
    add(0, 0, 0, 0, 0,   0, 2, 0, 0,  3, 2, 1);  // disable keeps counters
    add(0, 1, 0, 0, 0,   0, 2, 0, 0,  0, 0, 0);  // clear
    add(1, 0, 0, 0, 0,   0, 2, 1, 0,  0, 0, 0);
    add(1, 0, 1, 0, 0,   0, 2, 1, 0,  0, 0, 0);
    add(1, 0, 0, 1, 0,   1, 2, 2, 1,  0, 0, 0);
    add(1, 0, 0, 0, 1,   1, 0, 2, 1,  0, 0, 0);
    add(1, 1, 0, 0, 1,   1, 0, 2, 1,  0, 0, 0);  // clr beats repeat
    add(1, 0, 0, 0, 1,   1, 0, 2, 1,  0, 1, 0);
    add(1, 0, 0, 0, 1,   1, 0, 2, 1,  0, 2, 0);
    add(1, 0, 0, 0, 1,   1, 0, 2, 1,  0, 3, 0);
    add(1, 0, 0, 0, 1,   1, 0, 2, 1,  0, 3, 0);  // saturated

    #1 sys_rst_n = 1'b0;
    #2;
    chk("rst_wr_idx", 32'(wr_idx), 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd2);
    chk("rst_wr_addr", wr_base_addr, 32'h1000_0000);
    chk("rst_rd_addr", rd_base_addr, 32'h1012_C000);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    repeat (2) @(posedge clk_100Mhz);
    @(negedge clk_100Mhz) sys_rst_n = 1'b1;

    pwi = 2'd0; pri = 2'd2;
    foreach (vecs[k]) begin
      @(negedge clk_100Mhz);
      enable = vecs[k].en; clr_cnt = vecs[k].clr;
      wr_frame_start = vecs[k].ws; wr_frame_done = vecs[k].wd; rd_frame_start = vecs[k].rs;
      exp_q.push_back(vecs[k]);
      @(posedge clk_100Mhz);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_wr_idx", k), 32'(wr_idx), 32'(e.wi));
      chk($sformatf("v%0d_rd_idx", k), 32'(rd_idx), 32'(e.ri));
      chk($sformatf("v%0d_state", k), 32'(state), 32'(e.st));
      chk($sformatf("v%0d_rd_valid", k), 32'(rd_valid), 32'(e.v));
      chk($sformatf("v%0d_dropped", k), 32'(dropped_cnt), 32'(e.dr));
      chk($sformatf("v%0d_repeat", k), 32'(repeat_cnt), 32'(e.rp));
      chk($sformatf("v%0d_abort", k), 32'(abort_cnt), 32'(e.ab));
      chk($sformatf("v%0d_wr_addr", k), wr_base_addr, baddr(pwi));
      chk($sformatf("v%0d_rd_addr", k), rd_base_addr, baddr(pri));
      pwi = e.wi; pri = e.ri;
    end

    // Asynchronous reset in the middle of a frame, away from any clock edge.
    @(negedge clk_100Mhz);
    wr_frame_start = 1'b1; rd_frame_start = 1'b0;
    @(posedge clk_100Mhz);
    #3 sys_rst_n = 1'b0;
    #1;
    chk("arst_wr_idx", 32'(wr_idx), 32'd0);
    chk("arst_rd_idx", 32'(rd_idx), 32'd2);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_valid", 32'(rd_valid), 32'd0);
    chk("arst_repeat", 32'(repeat_cnt), 32'd0);
    chk("arst_wr_addr", wr_base_addr, 32'h1000_0000);
    chk("arst_rd_addr", rd_base_addr, 32'h1012_C000);
    wr_frame_start = 1'b0; enable = 1'b0;
    repeat (2) @(posedge clk_100Mhz);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_buffer_scheduler.md
Name: frame_buffer_scheduler

Overview:
- Triple-buffer scheduler for the camera-to-HDMI DDR path.
- Decides which of three DDR frame buffers the AXI4 writer fills and which one the AXI4 reader scans out, and publishes their base addresses.
- Prevents tearing: the reader only ever switches to a fully written frame.
- Sits in the clk_100Mhz domain between the frame-event pulses (already synchronised to clk_100Mhz) and the writer/reader address inputs.

Parameters:
ADDR_W, 32, address width
BASE_ADDR, 32'h1000_0000, DDR address of buffer 0
FRAME_BYTES, 32'h0009_6000, bytes per frame (640x480x2)
CNT_W, 16, width of the status counters

Ports:
clk_100Mhz  in  1  system/AXI clock
sys_rst_n  in  1  reset; asynchronous assert, active-low
enable  in  1  scheduler run enable (level)
clr_cnt  in  1  synchronous clear of all status counters (pulse)
wr_frame_start  in  1  writer began a frame (1-cycle pulse)
wr_frame_done  in  1  writer's last burst of the frame got BRESP (1-cycle pulse)
rd_frame_start  in  1  reader vsync / new scan-out frame (1-cycle pulse)
wr_base_addr  out  ADDR_W  base address for the writer
rd_base_addr  out  ADDR_W  base address for the reader
wr_idx  out  2  buffer index being written
rd_idx  out  2  buffer index being read
rd_valid  out  1  a complete frame exists; reader may fetch
state  out  2  FSM state (debug / ILA)
dropped_cnt  out  CNT_W  completed frames overwritten before being read
repeat_cnt  out  CNT_W  read frames that had no fresh data
abort_cnt  out  CNT_W  wr_frame_start received while a write was in progress

Behaviour:
- Reset values:
  - write_idx=0, ready_idx=1, read_idx=2; fresh=0; writing=0; state=IDLE.
  - rd_valid=0; all counters 0.
  - wr_base_addr=BASE_ADDR; rd_base_addr=BASE_ADDR+2*FRAME_BYTES.
- FSM states: IDLE=0, WAIT_FIRST=1, RUN=2.
  - IDLE: all pulses ignored. Transition to WAIT_FIRST when enable=1.
  - WAIT_FIRST: write tracking is active. rd_frame_start is ignored and not counted. The first qualified wr_frame_done moves the FSM to RUN and sets rd_valid=1 in the same edge.
  - Any state with enable=0: next edge goes to IDLE. Indices, fresh, writing and rd_valid return to their reset values. Counters are kept.
- Write tracking:
  - wr_frame_start sets writing=1.
  - wr_frame_start while writing=1: abort_cnt+1; the same buffer is reused.
  - wr_frame_done with writing=0 (stray) is ignored.
- Qualified wr_frame_done (writing=1): swap write_idx and ready_idx, clear writing. If fresh was already 1, dropped_cnt+1. Set fresh=1.
- rd_frame_start in RUN:
  - fresh=1: swap read_idx and ready_idx, clear fresh.
  - fresh=0: read_idx unchanged, repeat_cnt+1.
- wr_frame_done and rd_frame_start in the same cycle: the done is applied first, so the reader takes the just-completed frame.
  - New indices: read=old write, write=old ready, ready=old read; fresh=0.
  - dropped_cnt increments only if fresh was 1 before the cycle. repeat_cnt does not increment.
  - In WAIT_FIRST the rd_frame_start half is ignored.
- wr_frame_start and wr_frame_done in the same cycle: the done is applied first, then writing=1 for the new buffer.
- Indices are always a permutation of {0,1,2}; the assertion bench checks this every cycle.
- Latency:
  - Indices, wr_idx/rd_idx and flags update on the edge after the pulse.
  - wr_base_addr and rd_base_addr are registered one cycle later, i.e. valid 2 cycles after the pulse.
- Address = BASE_ADDR + idx*FRAME_BYTES, computed with shift-add (no multiplier), truncated to ADDR_W.
- Counters saturate at all-ones. clr_cnt has priority over a same-cycle increment.

Decomposition:
- Package fb_sched_pkg holds:
  - state encodings IDLE/WAIT_FIRST/RUN;
  - reset index constants (0,1,2);
  - default BASE_ADDR and FRAME_BYTES.
- Sub-module fb_sat_counter (CNT_W-wide saturating counter with inc and clr) is instantiated three times.
- Remaining logic (FSM, index swap, address registers) stays in the top module.

Test Plan:
- Reset check: assert sys_rst_n=0 -> wr_idx=0, rd_idx=2, wr_base_addr=0x10000000, rd_base_addr=0x1012C000, state=0, rd_valid=0.
- First frame: enable=1, wr_frame_start, wr_frame_done -> state=2, rd_valid=1, wr_idx=1, wr_base_addr=0x10096000 two cycles after the done. Then rd_frame_start -> rd_idx=0, rd_base_addr=0x10000000.
- Dropped and repeated frames in RUN:
  - Two complete write frames with no read -> dropped_cnt=1.
  - Then three rd_frame_start with no new done -> the first consumes, repeat_cnt=2.
- Simultaneous events: from write=1, ready=2, read=0, fresh=0, pulse wr_frame_done and rd_frame_start together -> read=1, write=2, ready=0, fresh=0, repeat_cnt unchanged.
- Stray and abort pulses: wr_frame_done without a prior start -> no index change. Two wr_frame_start pulses -> abort_cnt=1, wr_idx unchanged.
- Reset and disable mid-operation:
  - Assert sys_rst_n asynchronously mid-frame -> outputs take reset values without a clock edge.
  - Separately, drop enable in RUN -> state=0, indices reset, counters preserved.
  - Then clr_cnt -> all counters 0.
